// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage, the EX/MEM and MEM/WB bypass sources and
// the ID/EX stage. The master modport is the upstream pipeline; the slave is the stage.
interface id_ex_stage_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned RA = 5
);
  // Pipeline control
  logic          stall_i;
  logic          flush_i;

  // Decoded instruction from ID
  logic          id_valid;
  logic [RA-1:0] id_rs_addr;
  logic [RA-1:0] id_rt_addr;
  logic [RA-1:0] id_rd_addr;
  logic [W-1:0]  id_rs_data;
  logic [W-1:0]  id_rt_data;
  logic [15:0]   id_imm;
  logic          id_alu_src;
  logic          id_uses_rt;
  logic [2:0]    id_alu_ctrl;
  logic          id_reg_write;
  logic          id_mem_read;

  // Bypass sources
  logic          exmem_reg_write;
  logic [RA-1:0] exmem_rd;
  logic [W-1:0]  exmem_res;
  logic          memwb_reg_write;
  logic [RA-1:0] memwb_rd;
  logic [W-1:0]  memwb_data;

  // Stage outputs
  logic [W-1:0]  data0;
  logic [W-1:0]  data1;
  logic [2:0]    alu_ctrl;
  logic [RA-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_valid;
  logic          hazard_stall;

  modport master (
    output stall_i, flush_i,
    output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
    output id_imm, id_alu_src, id_uses_rt, id_alu_ctrl, id_reg_write, id_mem_read,
    output exmem_reg_write, exmem_rd, exmem_res,
    output memwb_reg_write, memwb_rd, memwb_data,
    input  data0, data1, alu_ctrl, ex_rd, ex_reg_write, ex_mem_read, ex_valid,
    input  hazard_stall
  );

  modport slave (
    input  stall_i, flush_i,
    input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
    input  id_imm, id_alu_src, id_uses_rt, id_alu_ctrl, id_reg_write, id_mem_read,
    input  exmem_reg_write, exmem_rd, exmem_res,
    input  memwb_reg_write, memwb_rd, memwb_data,
    output data0, data1, alu_ctrl, ex_rd, ex_reg_write, ex_mem_read, ex_valid,
    output hazard_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with the operand front end of the EX stage.
// Captures decoded operands/control, sign-extends the immediate and resolves RAW hazards.
// Build option: define FWD_EN for the EX/MEM + MEM/WB bypass network (only load-use stalls).
// Without FWD_EN, operands come from the captured register-file reads only and any RAW
// against the EX-stage or EX/MEM writer stalls ID until the writer reaches MEM/WB.
module id_ex_stage #(
  parameter int unsigned W      = 32,
  parameter int unsigned RA     = 5,
  parameter logic [2:0]  BUBBLE = 3'd7
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_read;
    logic          alu_src;
    logic [2:0]    alu_ctrl;
    logic [RA-1:0] rd;
    logic [RA-1:0] rs_addr;
    logic [RA-1:0] rt_addr;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic [W-1:0]  imm_ext;
  } stage_t;

  stage_t stage_q, stage_d;

  logic          ex_raw;      // ID reads the register the EX-stage instruction writes
  logic          exmem_raw;   // ID reads the register the EX/MEM instruction writes
  logic          load_use;
  logic          raw_stall;
  logic          hazard;
  logic [W-1:0]  fwd_rs;
  logic [W-1:0]  fwd_rt;
  logic [W-1:0]  id_imm_ext;

  assign id_imm_ext = {{(W-16){bus.id_imm[15]}}, bus.id_imm};

  // RAW detection against the instruction sitting in EX and the one in EX/MEM.
  always_comb begin
    ex_raw    = bus.id_valid && (stage_q.rd != '0) &&
                ((stage_q.rd == bus.id_rs_addr) ||
                 (bus.id_uses_rt && (stage_q.rd == bus.id_rt_addr)));
    exmem_raw = bus.id_valid && (bus.exmem_rd != '0) &&
                ((bus.exmem_rd == bus.id_rs_addr) ||
                 (bus.id_uses_rt && (bus.exmem_rd == bus.id_rt_addr)));
    load_use  = stage_q.valid && stage_q.mem_read && ex_raw;
`ifdef FWD_EN
    raw_stall = load_use;
`else
    raw_stall = load_use ||
                (stage_q.valid && stage_q.reg_write && ex_raw) ||
                (bus.exmem_reg_write && exmem_raw);
`endif
    // A squashed ID instruction must not stall the front end.
    hazard    = raw_stall && !bus.flush_i;
  end

  // Next-state selection: flush beats external stall beats hazard bubble beats capture.
  always_comb begin
    stage_d = stage_q;
    if (bus.flush_i) begin
      stage_d.valid     = 1'b0;
      stage_d.reg_write = 1'b0;
      stage_d.mem_read  = 1'b0;
    end else if (bus.stall_i) begin
      stage_d = stage_q;
    end else if (hazard) begin
      stage_d.valid     = 1'b0;
      stage_d.reg_write = 1'b0;
      stage_d.mem_read  = 1'b0;
    end else begin
      stage_d.valid     = bus.id_valid;
      stage_d.reg_write = bus.id_valid && bus.id_reg_write;
      stage_d.mem_read  = bus.id_valid && bus.id_mem_read;
      stage_d.alu_src   = bus.id_alu_src;
      stage_d.alu_ctrl  = bus.id_alu_ctrl;
      stage_d.rd        = bus.id_rd_addr;
      stage_d.rs_addr   = bus.id_rs_addr;
      stage_d.rt_addr   = bus.id_rt_addr;
      stage_d.rs_data   = bus.id_rs_data;
      stage_d.rt_data   = bus.id_rt_data;
      stage_d.imm_ext   = id_imm_ext;
    end
  end

  // Stage register; reset empties the stage immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

`ifdef FWD_EN
  // Operand bypass: EX/MEM has priority over MEM/WB; r0 is never forwarded.
  always_comb begin
    fwd_rs = stage_q.rs_data;
    if (bus.exmem_reg_write && (bus.exmem_rd == stage_q.rs_addr) && (stage_q.rs_addr != '0)) begin
      fwd_rs = bus.exmem_res;
    end else if (bus.memwb_reg_write && (bus.memwb_rd == stage_q.rs_addr) &&
                 (stage_q.rs_addr != '0)) begin
      fwd_rs = bus.memwb_data;
    end

    fwd_rt = stage_q.rt_data;
    if (bus.exmem_reg_write && (bus.exmem_rd == stage_q.rt_addr) && (stage_q.rt_addr != '0)) begin
      fwd_rt = bus.exmem_res;
    end else if (bus.memwb_reg_write && (bus.memwb_rd == stage_q.rt_addr) &&
                 (stage_q.rt_addr != '0)) begin
      fwd_rt = bus.memwb_data;
    end
  end
`else
  // Operands straight from the captured register-file reads.
  always_comb begin
    fwd_rs = stage_q.rs_data;
    fwd_rt = stage_q.rt_data;
  end

  // Bypass sources and source addresses have no consumer in this build.
  logic unused_fwd_srcs;
  assign unused_fwd_srcs = ^{bus.exmem_res, bus.memwb_reg_write, bus.memwb_rd,
                             bus.memwb_data, stage_q.rs_addr, stage_q.rt_addr};
`endif

  // ALU-facing outputs; an empty stage presents the bubble opcode.
  always_comb begin
    bus.data0        = fwd_rs;
    bus.data1        = stage_q.alu_src ? stage_q.imm_ext : fwd_rt;
    bus.alu_ctrl     = stage_q.valid ? stage_q.alu_ctrl : BUBBLE;
    bus.ex_rd        = stage_q.rd;
    bus.ex_reg_write = stage_q.reg_write;
    bus.ex_mem_read  = stage_q.mem_read;
    bus.ex_valid     = stage_q.valid;
    bus.hazard_stall = hazard;
  end

`ifndef SYNTHESIS
  // A bubble never carries side effects.
  bubble_quiet_a: assert property (@(posedge clk) disable iff (!rst_n)
    !stage_q.valid |-> !(stage_q.reg_write || stage_q.mem_read));
  // Squash always masks the hazard request.
  flush_masks_a: assert property (@(posedge clk) disable iff (!rst_n)
    bus.flush_i |-> !hazard);
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run
// checked against a behavioural model of the stage contents.
module tb_id_ex_stage;
  localparam int unsigned W  = 32;
  localparam int unsigned RA = 5;
`ifdef FWD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  id_ex_stage_if #(.W(W), .RA(RA)) bus ();

  id_ex_stage #(.W(W), .RA(RA), .BUBBLE(3'd7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model of what the stage should hold.
  typedef struct {
    bit          valid;
    bit          rw;
    bit          mr;
    bit          alu_src;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
  } stage_m_t;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [15:0] imm,
                          input logic alu_src, input logic uses_rt, input logic [2:0] ctrl,
                          input logic rw, input logic mr);
    bus.id_valid     = v;
    bus.id_rs_addr   = rs;
    bus.id_rt_addr   = rt;
    bus.id_rd_addr   = rd;
    bus.id_rs_data   = rsd;
    bus.id_rt_data   = rtd;
    bus.id_imm       = imm;
    bus.id_alu_src   = alu_src;
    bus.id_uses_rt   = uses_rt;
    bus.id_alu_ctrl  = ctrl;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
  endtask

  task automatic set_exmem(input logic w, input logic [4:0] rd, input logic [31:0] res);
    bus.exmem_reg_write = w;
    bus.exmem_rd        = rd;
    bus.exmem_res       = res;
  endtask

  task automatic set_memwb(input logic w, input logic [4:0] rd, input logic [31:0] d);
    bus.memwb_reg_write = w;
    bus.memwb_rd        = rd;
    bus.memwb_data      = d;
  endtask

  task automatic idle_all();
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    set_exmem(1'b0, 5'd0, 32'h0);
    set_memwb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.data0, bus.data1, bus.hazard_stall} !==
        {1'b0, 3'd7, 32'h0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_initial: got %h want %h",
               {bus.ex_valid, bus.alu_ctrl, bus.data0, bus.data1, bus.hazard_stall},
               {1'b0, 3'd7, 32'h0, 32'h0, 1'b0});
    end
    rst_n = 1'b1;
    tick();
    drive_id(1'b1, 5'd1, 5'd2, 5'd9, 32'h1234, 32'h5678, 16'h3, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    tick();
    vectors++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.data0, bus.data1} !== {1'b1, 3'd2, 32'h1234, 32'h5678})
    begin
      miscompares++;
      $display("FAIL reset_capture: got %h want %h",
               {bus.ex_valid, bus.alu_ctrl, bus.data0, bus.data1},
               {1'b1, 3'd2, 32'h1234, 32'h5678});
    end
    // Asynchronous reset while an instruction is being presented.
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.data0, bus.data1, bus.hazard_stall, bus.ex_reg_write,
         bus.ex_mem_read, bus.ex_rd} !==
        {1'b0, 3'd7, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_async: got %h want %h",
               {bus.ex_valid, bus.alu_ctrl, bus.data0, bus.data1, bus.hazard_stall},
               {1'b0, 3'd7, 32'h0, 32'h0, 1'b0});
    end
    idle_all();
    #2;
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({bus.ex_valid, bus.alu_ctrl} !== {1'b0, 3'd7}) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", {bus.ex_valid, bus.alu_ctrl}, {1'b0, 3'd7});
    end
  endtask

  task automatic test_exmem_forward();
    idle_all();
    tick();
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 16'h0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    tick();
    // sub r4,r3,r1 with a stale register-file value for r3
    drive_id(1'b1, 5'd3, 5'd1, 5'd4, 32'h0, 32'h5, 16'h0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
    #1;
`ifdef FWD_EN
    vectors++;
    if (bus.hazard_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_no_stall: got %b want 0", bus.hazard_stall);
    end
    tick();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    set_exmem(1'b1, 5'd3, 32'h10);
    #1;
`else
    vectors++;
    if (bus.hazard_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_ex_stall: got %b want 1", bus.hazard_stall);
    end
    tick();
    set_exmem(1'b1, 5'd3, 32'h10);
    #1;
    vectors++;
    if ({bus.hazard_stall, bus.ex_valid, bus.alu_ctrl} !== {1'b1, 1'b0, 3'd7}) begin
      miscompares++;
      $display("FAIL raw_exmem_stall: got %h want %h",
               {bus.hazard_stall, bus.ex_valid, bus.alu_ctrl}, {1'b1, 1'b0, 3'd7});
    end
    tick();
    set_exmem(1'b0, 5'd0, 32'h0);
    set_memwb(1'b1, 5'd3, 32'h10);
    bus.id_rs_data = 32'h10;
    #1;
    vectors++;
    if (bus.hazard_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL raw_release: got %b want 0", bus.hazard_stall);
    end
    tick();
    idle_all();
    #1;
`endif
    vectors++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.data0, bus.data1} !== {1'b1, 3'd6, 32'h10, 32'h5}) begin
      miscompares++;
      $display("FAIL exmem_forward: got %h want %h",
               {bus.ex_valid, bus.alu_ctrl, bus.data0, bus.data1},
               {1'b1, 3'd6, 32'h10, 32'h5});
    end
    idle_all();
  endtask

  task automatic test_double_match();
    logic [31:0] want;
    idle_all();
    tick();
    drive_id(1'b1, 5'd5, 5'd0, 5'd7, 32'h55, 32'h0, 16'h1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
    tick();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    set_exmem(1'b1, 5'd5, 32'hA);
    set_memwb(1'b1, 5'd5, 32'hB);
    #1;
    want = FwdOn ? 32'hA : 32'h55;
    vectors++;
    if ({bus.data0, bus.data1} !== {want, 32'h1}) begin
      miscompares++;
      $display("FAIL double_match: got %h want %h", {bus.data0, bus.data1}, {want, 32'h1});
    end
    set_exmem(1'b1, 5'd6, 32'hA);
    #1;
    want = FwdOn ? 32'hB : 32'h55;
    vectors++;
    if (bus.data0 !== want) begin
      miscompares++;
      $display("FAIL memwb_only: got %h want %h", bus.data0, want);
    end
    set_exmem(1'b0, 5'd5, 32'hA);
    set_memwb(1'b0, 5'd5, 32'hB);
    #1;
    vectors++;
    if (bus.data0 !== 32'h55) begin
      miscompares++;
      $display("FAIL no_writer: got %h want %h", bus.data0, 32'h55);
    end
    // Register 0 is never forwarded.
    idle_all();
    drive_id(1'b1, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 16'h0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    idle_all();
    set_exmem(1'b1, 5'd0, 32'hFF);
    set_memwb(1'b1, 5'd0, 32'hEE);
    #1;
    vectors++;
    if ({bus.ex_valid, bus.data0, bus.data1} !== {1'b1, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL r0_no_forward: got %h want %h", {bus.ex_valid, bus.data0, bus.data1},
               {1'b1, 32'h0, 32'h0});
    end
    idle_all();
  endtask

  task automatic test_load_use();
    idle_all();
    tick();
    drive_id(1'b1, 5'd1, 5'd0, 5'd2, 32'h100, 32'h0, 16'h0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 5'd2, 5'd2, 5'd1, 32'h0, 32'h0, 16'h0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    #1;
    vectors++;
    if ({bus.hazard_stall, bus.ex_valid, bus.ex_mem_read, bus.ex_rd} !==
        {1'b1, 1'b1, 1'b1, 5'd2}) begin
      miscompares++;
      $display("FAIL load_use_detect: got %h want %h",
               {bus.hazard_stall, bus.ex_valid, bus.ex_mem_read, bus.ex_rd},
               {1'b1, 1'b1, 1'b1, 5'd2});
    end
    tick();
    set_exmem(1'b1, 5'd2, 32'h100);
    #1;
    vectors++;
    if ({bus.hazard_stall, bus.ex_valid, bus.alu_ctrl, bus.ex_reg_write} !==
        {!FwdOn, 1'b0, 3'd7, 1'b0}) begin
      miscompares++;
      $display("FAIL load_use_bubble: got %h want %h",
               {bus.hazard_stall, bus.ex_valid, bus.alu_ctrl, bus.ex_reg_write},
               {!FwdOn, 1'b0, 3'd7, 1'b0});
    end
`ifndef FWD_EN
    tick();
    set_exmem(1'b0, 5'd0, 32'h0);
    set_memwb(1'b1, 5'd2, 32'h77);
    bus.id_rs_data = 32'h77;
    bus.id_rt_data = 32'h77;
    #1;
    vectors++;
    if ({bus.hazard_stall, bus.ex_valid} !== {1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL load_use_release: got %h want %h", {bus.hazard_stall, bus.ex_valid}, 2'b00);
    end
`endif
    tick();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    set_exmem(1'b0, 5'd0, 32'h0);
    set_memwb(1'b1, 5'd2, 32'h77);
    #1;
    vectors++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.data0, bus.data1} !== {1'b1, 3'd2, 32'h77, 32'h77})
    begin
      miscompares++;
      $display("FAIL load_use_data: got %h want %h",
               {bus.ex_valid, bus.alu_ctrl, bus.data0, bus.data1},
               {1'b1, 3'd2, 32'h77, 32'h77});
    end
    idle_all();
  endtask

  task automatic test_flush_stall();
    idle_all();
    tick();
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 16'h0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    bus.flush_i = 1'b1;
    bus.stall_i = 1'b1;
    drive_id(1'b1, 5'd4, 5'd5, 5'd6, 32'h33, 32'h44, 16'h0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    tick();
    idle_all();
    #1;
    vectors++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.ex_reg_write, bus.ex_mem_read} !==
        {1'b0, 3'd7, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL flush_over_stall: got %h want %h",
               {bus.ex_valid, bus.alu_ctrl, bus.ex_reg_write, bus.ex_mem_read},
               {1'b0, 3'd7, 1'b0, 1'b0});
    end
    // Load in EX with a dependent in ID: flush masks the hazard.
    drive_id(1'b1, 5'd1, 5'd0, 5'd2, 32'h100, 32'h0, 16'h0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 5'd2, 5'd0, 5'd1, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
    bus.flush_i = 1'b1;
    #1;
    vectors++;
    if (bus.hazard_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_masks_hazard: got %b want 0", bus.hazard_stall);
    end
    bus.flush_i = 1'b0;
    #1;
    vectors++;
    if (bus.hazard_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL hazard_unmasked: got %b want 1", bus.hazard_stall);
    end
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    drive_id(1'b1, 5'd4, 5'd6, 5'd8, 32'h40, 32'h60, 16'h0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    tick();
    // External stall holds everything for three cycles.
    bus.stall_i = 1'b1;
    drive_id(1'b1, 5'd1, 5'd1, 5'd9, 32'h99, 32'h98, 16'h0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if ({bus.ex_valid, bus.alu_ctrl, bus.ex_rd, bus.ex_reg_write, bus.data0, bus.data1} !==
          {1'b1, 3'd3, 5'd8, 1'b1, 32'h40, 32'h60}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got %h want %h", c,
                 {bus.ex_valid, bus.alu_ctrl, bus.ex_rd, bus.ex_reg_write, bus.data0, bus.data1},
                 {1'b1, 3'd3, 5'd8, 1'b1, 32'h40, 32'h60});
      end
      if (c < 3) tick();
    end
    idle_all();
  endtask

  task automatic test_immediate();
    idle_all();
    tick();
    drive_id(1'b1, 5'd1, 5'd0, 5'd2, 32'h3, 32'h0, 16'hFFFE, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd1, 5'd0, 5'd4, 32'h3, 32'h0, 16'h7FFF, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    #1;
    vectors++;
    if ({bus.data0, bus.data1} !== {32'h3, 32'hFFFFFFFE}) begin
      miscompares++;
      $display("FAIL imm_negative: got %h want %h", {bus.data0, bus.data1},
               {32'h3, 32'hFFFFFFFE});
    end
    tick();
    // ID reads r3: a MEM/WB writer never stalls, an EX/MEM writer stalls only without bypass.
    drive_id(1'b1, 5'd3, 5'd0, 5'd5, 32'h0, 32'h0, 16'h0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    #1;
    vectors++;
    if ({bus.data1, bus.alu_ctrl} !== {32'h00007FFF, 3'd0}) begin
      miscompares++;
      $display("FAIL imm_positive: got %h want %h", {bus.data1, bus.alu_ctrl},
               {32'h00007FFF, 3'd0});
    end
    set_memwb(1'b1, 5'd3, 32'h1);
    #1;
    vectors++;
    if (bus.hazard_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL memwb_no_stall: got %b want 0", bus.hazard_stall);
    end
    set_exmem(1'b1, 5'd3, 32'h2);
    #1;
    vectors++;
    if (bus.hazard_stall !== !FwdOn) begin
      miscompares++;
      $display("FAIL exmem_raw_stall: got %b want %b", bus.hazard_stall, !FwdOn);
    end
    bus.id_rs_addr = 5'd0;
    set_exmem(1'b1, 5'd0, 32'h2);
    #1;
    vectors++;
    if (bus.hazard_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL r0_no_stall: got %b want 0", bus.hazard_stall);
    end
    idle_all();
  endtask

  function automatic logic [31:0] bypass(input logic [4:0] r, input logic [31:0] rf);
    logic [31:0] v;
    v = rf;
    if (FwdOn && r != 5'd0 && bus.exmem_reg_write && bus.exmem_rd == r) v = bus.exmem_res;
    else if (FwdOn && r != 5'd0 && bus.memwb_reg_write && bus.memwb_rd == r) v = bus.memwb_data;
    return v;
  endfunction

  function automatic bit id_reads(input logic [4:0] r);
    return bus.id_valid && r != 5'd0 &&
           (r == bus.id_rs_addr || (bus.id_uses_rt && r == bus.id_rt_addr));
  endfunction

  task automatic test_random();
    stage_m_t m;
    logic [2:0] ops [5];
    bit exp_hz;
    logic [2:0] exp_ctrl;
    logic [31:0] exp_d0, exp_d1;
    ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    idle_all();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    m = '{default: '0};
    tick();
    for (int n = 0; n < 400; n++) begin
      bus.flush_i = ($urandom_range(0, 15) == 0);
      bus.stall_i = ($urandom_range(0, 9) == 0);
      drive_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), $urandom, $urandom, 16'($urandom),
               1'($urandom), 1'($urandom), ops[$urandom_range(0, 4)], 1'($urandom),
               $urandom_range(0, 2) == 0);
      set_exmem(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      set_memwb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      #1;
      exp_hz = !bus.flush_i &&
               ((m.valid && m.mr && id_reads(m.rd)) ||
                (!FwdOn && ((m.valid && m.rw && id_reads(m.rd)) ||
                            (bus.exmem_reg_write && id_reads(bus.exmem_rd)))));
      exp_ctrl = m.valid ? m.ctrl : 3'd7;
      vectors++;
      if ({bus.hazard_stall, bus.ex_valid, bus.alu_ctrl, bus.ex_reg_write, bus.ex_mem_read} !==
          {exp_hz, m.valid, exp_ctrl, m.rw, m.mr}) begin
        miscompares++;
        $display("FAIL rand_ctrl[%0d]: got %b want %b", n,
                 {bus.hazard_stall, bus.ex_valid, bus.alu_ctrl, bus.ex_reg_write,
                  bus.ex_mem_read}, {exp_hz, m.valid, exp_ctrl, m.rw, m.mr});
      end
      if (m.valid) begin
        exp_d0 = bypass(m.rs, m.rsd);
        exp_d1 = m.alu_src ? m.imm : bypass(m.rt, m.rtd);
        vectors++;
        if ({bus.ex_rd, bus.data0, bus.data1} !== {m.rd, exp_d0, exp_d1}) begin
          miscompares++;
          $display("FAIL rand_data[%0d]: got %h want %h", n,
                   {bus.ex_rd, bus.data0, bus.data1}, {m.rd, exp_d0, exp_d1});
        end
      end
      if (bus.flush_i || (!bus.stall_i && exp_hz)) begin
        m.valid = 1'b0;
        m.rw    = 1'b0;
        m.mr    = 1'b0;
      end else if (!bus.stall_i) begin
        m.valid   = bus.id_valid;
        m.rw      = bus.id_valid && bus.id_reg_write;
        m.mr      = bus.id_valid && bus.id_mem_read;
        m.alu_src = bus.id_alu_src;
        m.ctrl    = bus.id_alu_ctrl;
        m.rd      = bus.id_rd_addr;
        m.rs      = bus.id_rs_addr;
        m.rt      = bus.id_rt_addr;
        m.rsd     = bus.id_rs_data;
        m.rtd     = bus.id_rt_data;
        m.imm     = 32'($signed(bus.id_imm));
      end
      tick();
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_exmem_forward();
    test_double_match();
    test_load_use();
    test_flush_stall();
    test_immediate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
